// File: rtl/vdp_cpu_port.sv
// CPU access port of the VDP: decodes Z80 data/control port strobes into VRAM,
// CRAM and register writes, and keeps the auto-incrementing address and read-ahead buffer.
//
// state | meaning
// IDLE  | accepting CPU strobes (cpu_ready=1)
// RD    | prefetch address on vram_a, VRAM read in flight
// CAP   | vram_di valid: capture into rbuf and bump addr
module vdp_cpu_port #(
    parameter bit GG_CRAM = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic        cpu_port,
    input  logic [7:0]  cpu_di,
    output logic [7:0]  cpu_do,
    output logic        cpu_ready,
    input  logic [7:0]  status_in,
    output logic        status_read,
    output logic [13:0] vram_a,
    output logic        vram_we,
    output logic [7:0]  vram_do,
    input  logic [7:0]  vram_di,
    output logic        cram_we,
    output logic [5:0]  cram_a,
    output logic [11:0] cram_do,
    output logic        reg_we,
    output logic [3:0]  reg_a,
    output logic [7:0]  reg_do
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [13:0] addr;
    logic [1:0]  code;
    logic        pending;
    logic [7:0]  rbuf;
    logic [7:0]  cram_lo;
    logic [7:0]  cmd_lo;

    logic        ctrl_wr;
    logic        data_wr;
    logic        ctrl_rd;
    logic        data_rd;
    logic        start_pf;

    assign cpu_ready = (state == IDLE);

    assign ctrl_wr  = cpu_ready & cpu_we & cpu_port;
    assign data_wr  = cpu_ready & cpu_we & ~cpu_port;
    assign ctrl_rd  = cpu_ready & cpu_re & cpu_port;
    assign data_rd  = cpu_ready & cpu_re & ~cpu_port;
    assign start_pf = data_rd | (ctrl_wr & pending & (cpu_di[7:6] == 2'b00));

    assign cpu_do      = cpu_port ? status_in : rbuf;
    assign status_read = ctrl_rd & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_pf) state_nxt = RD;
            RD:      state_nxt = CAP;
            CAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr    <= 14'd0;
            code    <= 2'd0;
            pending <= 1'b0;
            rbuf    <= 8'd0;
            cram_lo <= 8'd0;
            cmd_lo  <= 8'd0;
            vram_a  <= 14'd0;
            vram_we <= 1'b0;
            vram_do <= 8'd0;
            cram_we <= 1'b0;
            cram_a  <= 6'd0;
            cram_do <= 12'd0;
            reg_we  <= 1'b0;
            reg_a   <= 4'd0;
            reg_do  <= 8'd0;
        end else begin
            vram_we <= 1'b0;
            cram_we <= 1'b0;
            reg_we  <= 1'b0;

            if (ctrl_wr) begin
                if (!pending) begin
                    addr[7:0] <= cpu_di;
                    cmd_lo    <= cpu_di;
                    pending   <= 1'b1;
                end else begin
                    addr[13:8] <= cpu_di[5:0];
                    code       <= cpu_di[7:6];
                    pending    <= 1'b0;
                    if (cpu_di[7:6] == 2'd2) begin
                        reg_we <= 1'b1;
                        reg_a  <= cpu_di[3:0];
                        reg_do <= cmd_lo;
                    end
                    // Prefetch must use the address being completed by this byte.
                    if (cpu_di[7:6] == 2'd0) begin
                        vram_a <= {cpu_di[5:0], addr[7:0]};
                    end
                end
            end

            if (data_wr) begin
                pending <= 1'b0;
                rbuf    <= cpu_di;
                addr    <= addr + 14'd1;
                if (code != 2'd3) begin
                    vram_we <= 1'b1;
                    vram_a  <= addr;
                    vram_do <= cpu_di;
                end else if (GG_CRAM) begin
                    // GG palette entries are 12-bit words; only the odd byte commits.
                    if (!addr[0]) begin
                        cram_lo <= cpu_di;
                    end else begin
                        cram_we <= 1'b1;
                        cram_a  <= {addr[5:1], 1'b0};
                        cram_do <= {cpu_di[3:0], cram_lo};
                    end
                end else begin
                    cram_we <= 1'b1;
                    cram_a  <= addr[5:0];
                    cram_do <= {4'b0000, cpu_di};
                end
            end

            if (data_rd) begin
                pending <= 1'b0;
                vram_a  <= addr;
            end

            if (ctrl_rd) begin
                pending <= 1'b0;
            end

            if (state == CAP) begin
                rbuf <= vram_di;
                addr <= addr + 14'd1;
            end
        end
    end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Scoreboard bench for vdp_cpu_port: a behavioural port model queues expected
// VRAM/CRAM/register writes and read data; a monitor checks them as the DUT emits them.
module tb_vdp_cpu_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we, cpu_re, cpu_port;
    logic [7:0]  cpu_di, cpu_do, status_in;
    logic        cpu_ready, status_read;
    logic [13:0] vram_a;
    logic        vram_we;
    logic [7:0]  vram_do, vram_di;
    logic        cram_we;
    logic [5:0]  cram_a;
    logic [11:0] cram_do;
    logic        reg_we;
    logic [3:0]  reg_a;
    logic [7:0]  reg_do;

    always #5 clk = ~clk;

    vdp_cpu_port #(.GG_CRAM(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_port(cpu_port),
        .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_ready(cpu_ready),
        .status_in(status_in), .status_read(status_read),
        .vram_a(vram_a), .vram_we(vram_we), .vram_do(vram_do), .vram_di(vram_di),
        .cram_we(cram_we), .cram_a(cram_a), .cram_do(cram_do),
        .reg_we(reg_we), .reg_a(reg_a), .reg_do(reg_do)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int a;
        int d;
    } ev_t;

    ev_t q_vram[$];
    ev_t q_cram[$];
    ev_t q_reg[$];
    ev_t q_rd[$];   // a: 1 = status read, d: expected cpu_do

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(string name, int act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected activity, value 0x%0h at %0t", name, act, $time);
    endtask

    function automatic logic [7:0] init_byte(int a);
        return 8'((a * 73 + a / 256 + 5) % 256);
    endfunction

    // VRAM: registered read, one cycle after vram_a; unwritten cells hold init_byte().
    logic [7:0] mem [16384];
    bit         written [16384];
    always @(posedge clk) begin
        if (vram_we) begin
            mem[vram_a]     <= vram_do;
            written[vram_a] <= 1'b1;
        end
        vram_di <= written[vram_a] ? mem[vram_a] : init_byte(int'(vram_a));
    end

    // Monitor
    always @(negedge clk) begin
        if (mon_en) begin
            ev_t e;
            if (vram_we) begin
                if (q_vram.size() == 0) flag("vram_we", int'(vram_a));
                else begin
                    e = q_vram.pop_front();
                    check("vram_a", int'(vram_a), e.a);
                    check("vram_do", int'(vram_do), e.d);
                end
            end
            if (cram_we) begin
                if (q_cram.size() == 0) flag("cram_we", int'(cram_a));
                else begin
                    e = q_cram.pop_front();
                    check("cram_a", int'(cram_a), e.a);
                    check("cram_do", int'(cram_do), e.d);
                end
            end
            if (reg_we) begin
                if (q_reg.size() == 0) flag("reg_we", int'(reg_a));
                else begin
                    e = q_reg.pop_front();
                    check("reg_a", int'(reg_a), e.a);
                    check("reg_do", int'(reg_do), e.d);
                end
            end
            if (cpu_re) begin
                if (q_rd.size() == 0) flag("cpu_re", int'(cpu_do));
                else begin
                    e = q_rd.pop_front();
                    check(e.a != 0 ? "status_do" : "data_do", int'(cpu_do), e.d);
                    check("status_read", int'(status_read), e.a);
                end
            end else if (status_read) begin
                flag("status_read", 1);
            end
        end
    end

    // Reference model of the port
    int m_addr, m_code, m_pending, m_rbuf, m_cram_lo, m_lo;
    int m_vram[int];

    function automatic int ref_rd(int a);
        return m_vram.exists(a) ? m_vram[a] : int'(init_byte(a));
    endfunction

    task automatic model_reset();
        m_addr = 0; m_code = 0; m_pending = 0; m_rbuf = 0; m_cram_lo = 0; m_lo = 0;
    endtask

    task automatic strobe(bit we, bit port, logic [7:0] d, logic [7:0] stat);
        @(posedge clk); #1;
        check("ready_at_strobe", int'(cpu_ready), 1);
        cpu_we = we; cpu_re = !we; cpu_port = port; cpu_di = d; status_in = stat;
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_re = 1'b0;
    endtask

    // kind: 0 ctrl write, 1 data write, 2 data read, 3 ctrl (status) read
    task automatic op(int kind, logic [7:0] d);
        bit pf = 1'b0;
        int di = int'(d);
        logic [7:0] stat = 8'($urandom);
        case (kind)
            0: begin
                if (m_pending == 0) begin
                    m_addr = (m_addr / 256) * 256 + di;
                    m_lo = di;
                    m_pending = 1;
                end else begin
                    m_addr = (di % 64) * 256 + m_addr % 256;
                    m_code = di / 64;
                    m_pending = 0;
                    if (m_code == 0) pf = 1'b1;
                    if (m_code == 2) q_reg.push_back('{di % 16, m_lo});
                end
            end
            1: begin
                m_pending = 0;
                if (m_code != 3) begin
                    q_vram.push_back('{m_addr, di});
                    m_vram[m_addr] = di;
                end else if (m_addr % 2 == 0) begin
                    m_cram_lo = di;
                end else begin
                    q_cram.push_back('{m_addr % 64 - 1, (di % 16) * 256 + m_cram_lo});
                end
                m_rbuf = di;
                m_addr = (m_addr + 1) % 16384;
            end
            2: begin
                q_rd.push_back('{0, m_rbuf});
                m_pending = 0;
                pf = 1'b1;
            end
            default: begin
                q_rd.push_back('{1, int'(stat)});
                m_pending = 0;
            end
        endcase
        if (pf) begin
            m_rbuf = ref_rd(m_addr);
            m_addr = (m_addr + 1) % 16384;
        end
        strobe(kind <= 1, kind == 0 || kind == 3, d, stat);
        if (pf) begin
            @(negedge clk); check("busy_rd", int'(cpu_ready), 0);
            @(negedge clk); check("busy_cap", int'(cpu_ready), 0);
            @(negedge clk); check("ready_after_pf", int'(cpu_ready), 1);
        end else begin
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; cpu_port = 1'b0;
        cpu_di = 8'd0; status_in = 8'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cpu_ready", int'(cpu_ready), 1);
        check("rst_vram_a", int'(vram_a), 0);
        check("rst_vram_we", int'(vram_we), 0);
        check("rst_cram_we", int'(cram_we), 0);
        check("rst_reg_we", int'(reg_we), 0);
        check("rst_status_read", int'(status_read), 0);
        mon_en = 1'b1;

        // basic VRAM writes with auto-increment
        op(0, 8'h00); op(0, 8'h40); op(1, 8'hAA); op(1, 8'h55); op(1, 8'h66);
        // write 0x5A at 0x1234, then prefetch it back
        op(0, 8'h34); op(0, 8'h52); op(1, 8'h5A);
        op(0, 8'h34); op(0, 8'h12); op(2, 8'h00); op(1, 8'h99);
        // register write
        op(0, 8'h07); op(0, 8'h81);
        // GG CRAM word write
        op(0, 8'h04); op(0, 8'hC0); op(1, 8'h34); op(1, 8'h0F);
        // address wrap on write
        op(0, 8'hFF); op(0, 8'h7F); op(1, 8'h11); op(1, 8'h22);
        // status read clears pending
        op(0, 8'h12); op(3, 8'h00); op(0, 8'h34); op(0, 8'h50); op(1, 8'h77);
        // address wrap on prefetch
        op(0, 8'hFF); op(0, 8'h3F); op(2, 8'h00); op(1, 8'h42);
        // data access with pending keeps high address/code
        op(0, 8'h10); op(0, 8'h45); op(0, 8'h80); op(1, 8'h3C);

        // reset in the middle of a prefetch
        op(0, 8'h00);
        strobe(1'b1, 1'b1, 8'h20, 8'h00);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_vram_a", int'(vram_a), 0);
        check("midrst_ready", int'(cpu_ready), 1);
        repeat (2) @(negedge clk);
        op(2, 8'h00); op(2, 8'h00); op(1, 8'hE1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 11);
            logic [7:0] d = 8'($urandom);
            if (r <= 3)       op(0, d);
            else if (r <= 7)  op(1, d);
            else if (r <= 9)  op(2, d);
            else if (r == 10) op(3, d);
            else begin
                op(0, 8'($urandom_range(250, 255)));
                op(0, 8'($urandom_range(0, 3) * 64 + 63));
            end
        end

        repeat (5) @(negedge clk);
        check("q_vram_drained", q_vram.size(), 0);
        check("q_cram_drained", q_cram.size(), 0);
        check("q_reg_drained", q_reg.size(), 0);
        check("q_rd_drained", q_rd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
